// File: rtl/i2c_init_seq_pkg.sv
// Shared definitions for the init-table sequencer: FSM state encodings, table
// opcodes, entry layout and the delay counter sizing helper.
package i2c_init_seq_pkg;

   // FSM state encodings
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_FETCH     = 4'd1;
   localparam logic [3:0] ST_CAPTURE   = 4'd2;
   localparam logic [3:0] ST_DECODE    = 4'd3;
   localparam logic [3:0] ST_ISSUE     = 4'd4;
   localparam logic [3:0] ST_WAIT_DONE = 4'd5;
   localparam logic [3:0] ST_DELAY     = 4'd6;
   localparam logic [3:0] ST_FINISH    = 4'd7;
   localparam logic [3:0] ST_FAIL      = 4'd8;

   // Device-byte opcodes that are not real I2C device addresses
   localparam logic [7:0] OP_END   = 8'hFF;
   localparam logic [7:0] OP_DELAY = 8'hFE;

   // Entry field bit positions
   localparam int unsigned ENTRY_DEV_MSB  = 23;
   localparam int unsigned ENTRY_DEV_LSB  = 16;
   localparam int unsigned ENTRY_REG_MSB  = 15;
   localparam int unsigned ENTRY_REG_LSB  = 8;
   localparam int unsigned ENTRY_DATA_MSB = 7;
   localparam int unsigned ENTRY_DATA_LSB = 0;

   localparam int unsigned TABLE_DEPTH = 64;
   localparam int unsigned ENTRY_W     = 24;

   // One table entry, laid out to match the bit positions above
   typedef struct packed {
      logic [7:0] dev;
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   // Bits needed to hold the longest delay (255 units) without overflow
   function automatic int unsigned delay_cnt_width(input int unsigned ticks);
      longint unsigned max_val;
      int unsigned     w;
      max_val = 64'd255 * 64'(ticks) + 64'd1;
      w = $clog2(max_val);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/i2c_init_seq_delay_timer.sv
// Count-down timer for table delay entries. A load arms it with a cycle count;
// expired pulses during the last counted cycle (or the first, for a zero load).
module i2c_init_seq_delay_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             active_q, active_d;

   // Next-state: load, count down, flag the final cycle
   always_comb begin
      count_d  = count_q;
      active_d = active_q;
      expired  = 1'b0;
      if (load) begin
         count_d  = load_val;
         active_d = 1'b1;
      end else if (active_q) begin
         if (count_q <= CNT_W'(1)) begin
            expired  = 1'b1;
            active_d = 1'b0;
            count_d  = '0;
         end else begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         active_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/i2c_init_seq.sv
// Init-table sequencer: walks the init RAM entry by entry and turns each one
// into an I2C register write, a timed delay or end-of-table, then reports
// clean completion or the index of the entry whose retries ran out.
module i2c_init_seq
   import i2c_init_seq_pkg::*;
#(
   parameter int unsigned DELAY_TICKS = 50000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [5:0]  ram_addr,
   input  logic [23:0] ram_data,
   output logic        i2c_valid,
   input  logic        i2c_ready,
   output logic [7:0]  i2c_dev,
   output logic [7:0]  i2c_reg,
   output logic [7:0]  i2c_data,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [5:0]  err_index
);

   localparam int unsigned CNT_W       = delay_cnt_width(DELAY_TICKS);
   localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

   logic [3:0] state_q, state_d;
   logic [5:0] index_q, index_d;
   logic [2:0] retry_q, retry_d;
   entry_t     entry_q, entry_d;
   logic       valid_q, valid_d;
   logic [7:0] dev_q, dev_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] data_q, data_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic [5:0] err_index_q, err_index_d;

   logic             advance;
   logic             begin_seq;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_expired;

   i2c_init_seq_delay_timer #(
      .CNT_W (CNT_W)
   ) u_delay_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   // Next-state and output-register logic for the sequencer FSM
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      retry_d     = retry_q;
      entry_d     = entry_q;
      valid_d     = valid_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      data_d      = data_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      advance     = 1'b0;
      begin_seq   = 1'b0;
      timer_load  = 1'b0;
      timer_val   = CNT_W'(entry_q.data) * CNT_W'(DELAY_TICKS);

      case (state_q)
         ST_IDLE: begin
            begin_seq = start;
         end
         // ram_addr already holds the index; give the RAM its sampling cycle
         ST_FETCH: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            entry_d = entry_t'(ram_data);
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (entry_q.dev == OP_END) begin
               state_d = ST_FINISH;
            end else if (entry_q.dev == OP_DELAY) begin
               timer_load = 1'b1;
               state_d    = ST_DELAY;
            end else begin
               retry_d = '0;
               dev_d   = entry_q.dev;
               reg_d   = entry_q.addr;
               data_d  = entry_q.data;
               valid_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (valid_q && i2c_ready) begin
               valid_d = 1'b0;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (i2c_done) begin
               if (!i2c_nack) begin
                  advance = 1'b1;
               end else if (retry_q < RETRY_LIMIT) begin
                  retry_d = retry_q + 3'd1;
                  valid_d = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_FAIL;
               end
            end
         end
         ST_DELAY: begin
            advance = timer_expired;
         end
         ST_FINISH: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
            begin_seq = start;
         end
         ST_FAIL: begin
            error_d     = 1'b1;
            err_index_d = index_q;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
            begin_seq   = start;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Last entry completing ends the table; the index never wraps
      if (advance) begin
         if (index_q == 6'd63) begin
            state_d = ST_FINISH;
         end else begin
            index_d = index_q + 6'd1;
            state_d = ST_FETCH;
         end
      end

      // A restart from FINISH/FAIL overrides the status just posted
      if (begin_seq) begin
         done_d  = 1'b0;
         error_d = 1'b0;
         busy_d  = 1'b1;
         index_d = '0;
         retry_d = '0;
         state_d = ST_FETCH;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         retry_q     <= '0;
         entry_q     <= '0;
         valid_q     <= 1'b0;
         dev_q       <= '0;
         reg_q       <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         retry_q     <= retry_d;
         entry_q     <= entry_d;
         valid_q     <= valid_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
      end
   end

   assign ram_addr  = index_q;
   assign i2c_valid = valid_q;
   assign i2c_dev   = dev_q;
   assign i2c_reg   = reg_q;
   assign i2c_data  = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_index = err_index_q;

endmodule
